// File: rtl/turret_pkg.sv
// turret_pkg
// Shared definitions for the turret sprite pipeline: direction encoding,
// sprite geometry, screen extents and the transparent palette key.
package turret_pkg;

   // Clockwise quarter turns, matching the game-logic encoding of turret_dir.
   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   localparam int         SPRITE_SZ   = 32;
   localparam int         SPRITE_LOG2 = $clog2(SPRITE_SZ);
   localparam int         ADDR_W      = 2 * SPRITE_LOG2;
   localparam int         COORD_W     = 10;
   localparam logic [7:0] KEY_INDEX   = 8'd0;
   localparam int         H_ACTIVE    = 640;
   localparam int         V_ACTIVE    = 480;

endpackage

// File: rtl/turret_rot_addr.sv
// turret_rot_addr
// Combinational sprite rotation: maps the in-box offset (dx, dy) of a screen
// pixel to the {row, col} address of the stored, upward-facing sprite.
// Ports:
//   dx, dy : in  offset from the sprite's top-left corner, 0..SPRITE_SZ-1
//   dir    : in  turret facing (clockwise quarter turns)
//   addr   : out {row, col}, i.e. row*SPRITE_SZ + col
module turret_rot_addr
   import turret_pkg::*;
#(
   parameter int SZ_LOG2 = turret_pkg::SPRITE_LOG2
) (
   input  logic [SZ_LOG2-1:0]   dx,
   input  logic [SZ_LOG2-1:0]   dy,
   input  dir_t                 dir,
   output logic [2*SZ_LOG2-1:0] addr
);

   logic [SZ_LOG2-1:0] row;
   logic [SZ_LOG2-1:0] col;

   // The sprite is a power of two, so N-x (N = SPRITE_SZ-1) is simply ~x.
   always_comb begin
      row = dy;
      col = dx;
      case (dir)
         DIR_UP: begin
            row = dy;
            col = dx;
         end
         DIR_RIGHT: begin
            row = ~dx;
            col = dy;
         end
         DIR_DOWN: begin
            row = ~dy;
            col = ~dx;
         end
         DIR_LEFT: begin
            row = dx;
            col = ~dy;
         end
      endcase
   end

   assign addr = {row, col};

endmodule

// File: rtl/turret2_sprite_fetch.sv
// turret2_sprite_fetch
// Front end of the turret2 palette lookup. Each active pixel is hit-tested
// against the turret box, the rotated sprite address is issued to the
// external index ROM, and the returned palette index is presented with
// valid/opaque flags two cycles after the pixel.
//
// Flow control: valid-only pipeline. pix_valid qualifies DrawX/DrawY in the
// cycle it is high; index_valid qualifies index exactly two cycles later.
// There is no ready; the pipe never stalls and accepts one pixel per cycle.
//
// Ports:
//   Clk, Reset_n          : clock, asynchronous active-low reset
//   frame_start           : vsync pulse, latches turret_x/turret_y/turret_dir
//   pix_valid, DrawX/Y    : current pixel and its qualifier
//   turret_x/y, turret_dir: live turret position/facing from game logic
//   rom_addr / rom_data   : sprite index ROM read port (data one cycle later)
//   index, index_valid    : palette index and in-box flag
//   opaque                : index_valid and index is not the transparent key
module turret2_sprite_fetch
   import turret_pkg::*;
#(
   parameter int         SPRITE_SZ = turret_pkg::SPRITE_SZ,
   parameter int         ADDR_W    = turret_pkg::ADDR_W,
   parameter int         COORD_W   = turret_pkg::COORD_W,
   parameter logic [7:0] KEY_INDEX = turret_pkg::KEY_INDEX
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               frame_start,
   input  logic               pix_valid,
   input  logic [COORD_W-1:0] DrawX,
   input  logic [COORD_W-1:0] DrawY,
   input  logic [COORD_W-1:0] turret_x,
   input  logic [COORD_W-1:0] turret_y,
   input  logic [1:0]         turret_dir,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [7:0]         rom_data,
   output logic [7:0]         index,
   output logic               index_valid,
   output logic               opaque
);

   localparam int                 SZ_LOG2 = $clog2(SPRITE_SZ);
   localparam logic [COORD_W:0]   SZ_EXT  = (COORD_W+1)'(SPRITE_SZ);

   // Frame-latched turret placement; only frame_start may update these.
   logic [COORD_W-1:0] lx;
   logic [COORD_W-1:0] ly;
   dir_t               ldir;

   // One extra bit so a pixel left of / above the box borrows into the MSB
   // and fails the range test instead of wrapping into the sprite.
   logic [COORD_W:0]   dx;
   logic [COORD_W:0]   dy;
   logic               hit;
   logic [ADDR_W-1:0]  rot_addr;
   logic               hit_q1;

   assign dx  = {1'b0, DrawX} - {1'b0, lx};
   assign dy  = {1'b0, DrawY} - {1'b0, ly};
   assign hit = pix_valid && (dx < SZ_EXT) && (dy < SZ_EXT);

   turret_rot_addr #(
      .SZ_LOG2 (SZ_LOG2)
   ) u_rot (
      .dx   (dx[SZ_LOG2-1:0]),
      .dy   (dy[SZ_LOG2-1:0]),
      .dir  (ldir),
      .addr (rot_addr)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         lx          <= '0;
         ly          <= '0;
         ldir        <= DIR_UP;
         rom_addr    <= '0;
         hit_q1      <= 1'b0;
         index       <= '0;
         index_valid <= 1'b0;
         opaque      <= 1'b0;
      end else begin
         // A pixel in the frame_start cycle still sees the old latch, since
         // hit/rot_addr are computed from the register outputs.
         if (frame_start) begin
            lx   <= turret_x;
            ly   <= turret_y;
            ldir <= dir_t'(turret_dir);
         end
         // Address only moves on a hit to avoid needless ROM toggling.
         if (hit) begin
            rom_addr <= rot_addr;
         end
         hit_q1      <= hit;
         index       <= rom_data;
         index_valid <= hit_q1;
         opaque      <= hit_q1 && (rom_data != KEY_INDEX);
      end
   end

endmodule

// File: tb/tb_turret2_sprite_fetch.sv
// tb_turret2_sprite_fetch
// Directed bench for turret2_sprite_fetch with hand-computed expected values.
module tb_turret2_sprite_fetch;

   logic       Clk;
   logic       Reset_n;
   logic       frame_start;
   logic       pix_valid;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic [9:0] turret_x;
   logic [9:0] turret_y;
   logic [1:0] turret_dir;
   logic [9:0] rom_addr;
   logic [7:0] rom_data;
   logic [7:0] index;
   logic       index_valid;
   logic       opaque;

   int n_checks = 0;
   int n_fail   = 0;

   turret2_sprite_fetch dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .frame_start (frame_start),
      .pix_valid   (pix_valid),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .turret_x    (turret_x),
      .turret_y    (turret_y),
      .turret_dir  (turret_dir),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .index       (index),
      .index_valid (index_valid),
      .opaque      (opaque)
   );

   // clock / reset block
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL timeout: got no end of test, expected end before 200000");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // driver: frame_start pulse with new placement, no pixel
   task automatic latch(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d);
      @(negedge Clk);
      turret_x    = x;
      turret_y    = y;
      turret_dir  = d;
      frame_start = 1'b1;
      @(posedge Clk);
      #1 frame_start = 1'b0;
   endtask

   // driver: one pixel, rom_data held over the ROM cycle; checks t+1 and t+2
   task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                        input logic [7:0] data, input logic fs,
                        input logic exp_hit, input logic exp_opq, input logic [9:0] exp_addr);
      @(negedge Clk);
      DrawX       = x;
      DrawY       = y;
      rom_data    = data;
      pix_valid   = 1'b1;
      frame_start = fs;
      @(posedge Clk);
      #1;
      pix_valid   = 1'b0;
      frame_start = 1'b0;
      check({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
      @(posedge Clk);
      #1;
      check({tag, "_valid"}, 32'(index_valid), 32'(exp_hit));
      check({tag, "_opaque"}, 32'(opaque), 32'(exp_opq));
      if (exp_hit) check({tag, "_index"}, 32'(index), 32'(data));
   endtask

   initial begin
      Reset_n     = 1'b0;
      frame_start = 1'b0;
      pix_valid   = 1'b0;
      DrawX       = '0;
      DrawY       = '0;
      turret_x    = '0;
      turret_y    = '0;
      turret_dir  = '0;
      rom_data    = 8'hA5;
      repeat (3) @(posedge Clk);
      #1;
      check("rst_valid", 32'(index_valid), 32'd0);
      check("rst_opaque", 32'(opaque), 32'd0);
      check("rst_addr", 32'(rom_addr), 32'd0);
      check("rst_index", 32'(index), 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      check("idle_valid", 32'(index_valid), 32'd0);
      check("idle_opaque", 32'(opaque), 32'd0);
      check("idle_addr", 32'(rom_addr), 32'd0);

      // dir0 hit and rotations of the same pixel (dx=3, dy=2)
      latch(10'd100, 10'd50, 2'd0);
      pixel("dir0", 10'd103, 10'd52, 8'h2A, 1'b0, 1'b1, 1'b1, 10'd67);
      latch(10'd100, 10'd50, 2'd1);
      pixel("dir1", 10'd103, 10'd52, 8'h11, 1'b0, 1'b1, 1'b1, 10'd898);
      latch(10'd100, 10'd50, 2'd2);
      pixel("dir2", 10'd103, 10'd52, 8'h12, 1'b0, 1'b1, 1'b1, 10'd956);
      latch(10'd100, 10'd50, 2'd3);
      pixel("dir3", 10'd103, 10'd52, 8'h13, 1'b0, 1'b1, 1'b1, 10'd125);

      // transparency, misses and box edges
      latch(10'd100, 10'd50, 2'd0);
      pixel("transp", 10'd103, 10'd52, 8'h00, 1'b0, 1'b1, 1'b0, 10'd67);
      pixel("miss_left", 10'd99, 10'd50, 8'h44, 1'b0, 1'b0, 1'b0, 10'd67);
      pixel("miss_right", 10'd132, 10'd52, 8'h45, 1'b0, 1'b0, 1'b0, 10'd67);
      pixel("corner_br", 10'd131, 10'd81, 8'h07, 1'b0, 1'b1, 1'b1, 10'd1023);
      pixel("miss_below", 10'd100, 10'd82, 8'h46, 1'b0, 1'b0, 1'b0, 10'd1023);
      pixel("corner_tl", 10'd100, 10'd50, 8'h03, 1'b0, 1'b1, 1'b1, 10'd0);

      // mid-frame position change is ignored until frame_start
      @(negedge Clk);
      turret_x = 10'd200;
      pixel("midframe", 10'd103, 10'd52, 8'h21, 1'b0, 1'b1, 1'b1, 10'd67);
      pixel("fs_same_cyc", 10'd103, 10'd52, 8'h22, 1'b1, 1'b1, 1'b1, 10'd67);
      pixel("old_pos_miss", 10'd103, 10'd52, 8'h23, 1'b0, 1'b0, 1'b0, 10'd67);
      pixel("new_pos_hit", 10'd204, 10'd53, 8'h24, 1'b0, 1'b1, 1'b1, 10'd100);

      // right-edge clipping, no wrap to column 0
      latch(10'd630, 10'd50, 2'd0);
      pixel("clip_630", 10'd630, 10'd50, 8'h31, 1'b0, 1'b1, 1'b1, 10'd0);
      pixel("clip_639", 10'd639, 10'd50, 8'h32, 1'b0, 1'b1, 1'b1, 10'd9);
      pixel("clip_x0", 10'd0, 10'd50, 8'h33, 1'b0, 1'b0, 1'b0, 10'd9);
      pixel("clip_639_y81", 10'd639, 10'd81, 8'h34, 1'b0, 1'b1, 1'b1, 10'd1001);

      // reset asserted during a streaming hit
      @(negedge Clk);
      DrawX     = 10'd631;
      DrawY     = 10'd51;
      rom_data  = 8'h55;
      pix_valid = 1'b1;
      @(posedge Clk);
      #1;
      check("strm_addr", 32'(rom_addr), 32'd33);
      @(posedge Clk);
      #1;
      check("strm_valid", 32'(index_valid), 32'd1);
      check("strm_index", 32'(index), 32'h55);
      #1 Reset_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(index_valid), 32'd0);
      check("async_rst_opaque", 32'(opaque), 32'd0);
      check("async_rst_addr", 32'(rom_addr), 32'd0);
      check("async_rst_index", 32'(index), 32'd0);
      @(negedge Clk);
      pix_valid = 1'b0;
      Reset_n   = 1'b1;
      // latch cleared to (0,0,up): pixel (5,6) -> 6*32+5 = 197
      @(negedge Clk);
      DrawX     = 10'd5;
      DrawY     = 10'd6;
      rom_data  = 8'h66;
      pix_valid = 1'b1;
      @(posedge Clk);
      #1;
      pix_valid = 1'b0;
      check("post_rst_addr", 32'(rom_addr), 32'd197);
      check("post_rst_valid_t1", 32'(index_valid), 32'd0);
      @(posedge Clk);
      #1;
      check("post_rst_valid_t2", 32'(index_valid), 32'd1);
      check("post_rst_opaque_t2", 32'(opaque), 32'd1);
      check("post_rst_index_t2", 32'(index), 32'h66);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
